braille_cell_player: RTL and testbench
======================================

# braille_cell_player

Downstream stage of the ASCII-to-braille converter `top`. It buffers the 6-dot cells that `top` emits on `brout`/`valid` and replays them to a refreshable braille actuator. Each cell is held for a fixed raise time, then followed by an all-pins-down gap, so that multi-cell expansions (capital and number indicators) are never lost or overlapped. Its `ready` output is intended to drive `top`'s `G` enable for back-pressure.

## Interface
- `DEPTH`, 8: FIFO depth in cells, ≥2.
- `HOLD_CYC`, 16: cycles each cell is driven on the pins, ≥1.
- `GAP_CYC`, 4: cycles all pins are low between cells, ≥1.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, **asynchronous, active-low**.
- `cell_in` in [1:6]: braille dots 1..6 (bit 1 = dot 1), from `top.brout`.
- `cell_valid` in 1: each high cycle writes one cell, from `top.valid`.
- `ready` out 1: `!full`, combinational from the count register.
- `pin_drv` out [1:6]: actuator pin drive.
- `strobe` out 1: one-cycle pulse on the first cycle a new cell appears on `pin_drv`.
- `busy` out 1: high when the FSM is not in IDLE.
- `overflow` out 1: sticky; set when a write is dropped.

## Operation
- FIFO write: `cell_valid` high and (count < DEPTH, or a pop occurs in the same cycle). The cell is stored.
- Dropped write: `cell_valid` high, FIFO full, and no pop that cycle. The cell is discarded and `overflow` is set to 1. `overflow` stays set until reset.
- Pointers wrap modulo DEPTH. Count width is `$clog2(DEPTH+1)`.
- FSM states are IDLE, HOLD and GAP.
  - IDLE with count ≠ 0: pop; `pin_drv` ← head cell; `strobe` = 1; hold counter ← 1; go to HOLD.
  - IDLE with count = 0: stay in IDLE.
  - HOLD: when hold counter = HOLD_CYC, set `pin_drv` ← 0, reset the gap counter, and go to GAP. Otherwise increment the hold counter.
  - GAP: when gap counter = GAP_CYC:
    - if count ≠ 0, pop and load directly into HOLD with a `strobe` pulse, without visiting IDLE;
    - otherwise go to IDLE.
  - GAP: in any other cycle, increment the gap counter.
- A blank cell (6'b000000, a space) is played like any other cell: it still gets its strobe, HOLD and GAP.
- Simultaneous push and pop on an empty FIFO is not possible, because pop requires count ≠ 0 in the current cycle. Empty-FIFO bypass is not supported.
- Reset, including mid-HOLD or mid-GAP, immediately forces the following, and the FIFO contents are discarded:
  - `pin_drv` = 0, `strobe` = 0, `busy` = 0, `overflow` = 0
  - state = IDLE, count = 0, `ready` = 1

## Timing
- Reset values: `pin_drv` 0, `strobe` 0, `busy` 0, `overflow` 0, `ready` 1.
- Latency: a cell written at edge k into an empty, idle block appears on `pin_drv` at edge k+1, with `strobe` high during the cycle after edge k+1.
- Pins carry the cell for exactly HOLD_CYC cycles, then are 0 for exactly GAP_CYC cycles.
- Cell period under continuous load: HOLD_CYC + GAP_CYC cycles (20 at defaults).
- `ready` drops in the cycle after the write that makes count = DEPTH. It rises in the cycle after the next pop.
- `busy` rises with the first `strobe`. It falls on the edge that leaves the final GAP into IDLE.
- All outputs are registered, except `ready`.

## Structure
- Package `braille_pkg` holds:
  - `CELL_W` = 6;
  - the typedef `cell_t` (logic [1:6]);
  - the enum `player_state_t` {IDLE, HOLD, GAP}.
- Sub-module `braille_cell_fifo`: a parameterised synchronous FIFO with push, pop, full, empty, count and a drop flag.
- `braille_cell_player` instantiates the FIFO and contains the FSM, the two counters and the output registers.

## Test plan
- **Single cell:** reset, then one `cell_valid` pulse with 6'b100000 ("a"). Expect:
  - `pin_drv` = 100000 one edge later, for 16 cycles, with one `strobe` pulse;
  - then 0 for 4 cycles;
  - then `busy` = 0.
- **Back-to-back:** three cells written in consecutive cycles: 001111 (number sign), 100000, 110000. Expect:
  - three strobes spaced exactly 20 cycles apart;
  - cells played in order;
  - no pass through IDLE between cells;
  - `overflow` = 0.
- **Overflow:** 10 consecutive writes with DEPTH = 8 and the FSM idle at start. Expect:
  - the first cell is popped after one cycle;
  - `ready` = 0 after 9 writes;
  - the 10th write is dropped and `overflow` = 1;
  - exactly 9 cells are played.
- **Full with pop:** FIFO full and a write in the same cycle as a pop at GAP end. Expect the write to be accepted, count to stay at DEPTH, and `overflow` to remain 0.
- **Blank cell:** write 000000. Expect a `strobe` pulse, `busy` = 1 for 20 cycles and `pin_drv` = 0 throughout.
- **Reset mid-HOLD:** assert `rst` = 0 asynchronously, between clock edges, at hold cycle 7 with 3 cells queued. Expect:
  - `pin_drv` = 0 immediately, without waiting for a clock edge;
  - after `rst` = 1, no further strobes;
  - `ready` = 1 and `overflow` = 0.

Source files
------------

// File: rtl/braille_cell_player_pkg.sv
// Shared types for the braille cell player: cell encoding and FSM states.
package braille_pkg;

  localparam int CELL_W = 6;

  typedef logic [1:CELL_W] cell_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } player_state_t;

endpackage

// File: rtl/braille_cell_player_if.sv
// Cell handshake from the ASCII-to-braille converter into the player.
interface braille_cell_player_if;
  import braille_pkg::*;

  cell_t cell_in;
  logic  cell_valid;
  logic  ready;

  modport master (output cell_in, output cell_valid, input ready);
  modport slave  (input cell_in, input cell_valid, output ready);

endinterface

// File: rtl/braille_cell_player_fifo.sv
// Small synchronous cell FIFO; a pop frees a slot for a push in the same cycle.
module braille_cell_fifo
  import braille_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  cell_t         din,
  output cell_t         dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          drop
);

  cell_t         mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          wr_en;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
      if (wr_en && !pop)      count <= count + CW'(1);
      else if (pop && !wr_en) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/braille_cell_player.sv
// Buffers converter cells and replays each one on the actuator pins for a
// fixed raise time followed by an all-pins-down gap.
//
// state | meaning
// IDLE  | pins down, waiting for a queued cell
// HOLD  | current cell driven on pin_drv, hold_cnt counts 1..HOLD_CYC
// GAP   | pins down between cells, gap_cnt counts 1..GAP_CYC
module braille_cell_player
  import braille_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int HOLD_CYC = 16,
  parameter int GAP_CYC  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  braille_cell_player_if.slave        cell_if,
  output cell_t                       pin_drv,
  output logic                        strobe,
  output logic                        busy,
  output logic                        overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  player_state_t state;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic [CW-1:0] count;
  cell_t         head;
  logic          full;
  logic          empty;
  logic          drop;
  logic          pop;
  logic          gap_done;

  assign gap_done     = (state == GAP) && (gap_cnt == GW'(GAP_CYC));
  assign pop          = (count != '0) && ((state == IDLE) || gap_done);
  assign cell_if.ready = !full;

  braille_cell_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cell_if.cell_valid),
    .pop   (pop),
    .din   (cell_if.cell_in),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count),
    .drop  (drop)
  );

  always_ff @(posedge clk) begin
    if (rst && pop) assert (!empty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      pin_drv  <= '0;
      strobe   <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (drop) overflow <= 1'b1;
      // A pop from IDLE or at the end of GAP goes straight into HOLD.
      if (pop) begin
        pin_drv  <= head;
        strobe   <= 1'b1;
        busy     <= 1'b1;
        hold_cnt <= HW'(1);
        state    <= HOLD;
      end else begin
        case (state)
          HOLD: begin
            if (hold_cnt == HW'(HOLD_CYC)) begin
              pin_drv <= '0;
              gap_cnt <= GW'(1);
              state   <= GAP;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          GAP: begin
            if (gap_done) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_braille_cell_player.sv
// Directed bench for braille_cell_player with a timeline-based reference model.
module tb_braille_cell_player;
  import braille_pkg::*;

  localparam int DEPTH  = 8;
  localparam int HOLD   = 16;
  localparam int GAP    = 4;
  localparam int PERIOD = HOLD + GAP;

  logic  clk;
  logic  rst;
  cell_t pin_drv;
  logic  strobe;
  logic  busy;
  logic  overflow;

  braille_cell_player_if cif ();

  braille_cell_player #(.DEPTH(DEPTH), .HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .cell_if  (cif),
    .pin_drv  (pin_drv),
    .strobe   (strobe),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted cells and the edge at which the
  // current cell was popped; outputs follow from elapsed time in its period.
  int    cyc = 0;
  cell_t mq[$];
  cell_t m_cur;
  int    m_t0 = 0;
  bit    m_play = 0;
  bit    m_ovf = 0;
  int    msz;
  bit    mpop;
  int    el;
  cell_t e_pin;
  cell_t played[$];
  int    st_cyc[$];

  always begin
    @(posedge clk);
    cyc++;
    if (!rst) begin
      mq.delete();
      m_play = 0;
      m_ovf  = 0;
    end else begin
      msz  = mq.size();
      mpop = 0;
      if (!m_play) mpop = (msz != 0);
      else if (cyc - m_t0 == PERIOD) begin
        if (msz != 0) mpop = 1;
        else m_play = 0;
      end
      if (mpop) begin
        m_cur  = mq.pop_front();
        m_t0   = cyc;
        m_play = 1;
      end
      if (cif.cell_valid) begin
        if (msz < DEPTH || mpop) mq.push_back(cif.cell_in);
        else m_ovf = 1;
      end
    end
    #1;
    el    = cyc - m_t0;
    e_pin = (m_play && el < HOLD) ? m_cur : '0;
    chk("pin_drv",  int'(pin_drv),   int'(e_pin));
    chk("strobe",   int'(strobe),    int'(m_play && el == 0));
    chk("busy",     int'(busy),      int'(m_play));
    chk("overflow", int'(overflow),  int'(m_ovf));
    chk("ready",    int'(cif.ready), int'(mq.size() < DEPTH));
    if (strobe) begin
      played.push_back(pin_drv);
      st_cyc.push_back(cyc);
    end
  end

  cell_t stim[$];

  task automatic push_stim();
    foreach (stim[i]) begin
      @(negedge clk);
      cif.cell_valid = 1'b1;
      cif.cell_in    = stim[i];
    end
    @(negedge clk);
    cif.cell_valid = 1'b0;
    cif.cell_in    = '0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Park on the negedge just before the edge where elapsed reaches target+1.
  task automatic wait_elapsed(input int target);
    int guard = 0;
    while (!(m_play && (cyc - m_t0) == target) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_bound", int'(guard < 300), 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    wait_cyc(2);
    rst = 1'b1;
  endtask

  int n0;
  int busy_cnt;
  logic [5:0] pin_or;

  initial begin
    rst            = 1'b0;
    cif.cell_valid = 1'b0;
    cif.cell_in    = '0;
    #7;
    chk("rst_pin",   int'(pin_drv),   0);
    chk("rst_strobe", int'(strobe),   0);
    chk("rst_busy",  int'(busy),      0);
    chk("rst_ovf",   int'(overflow),  0);
    chk("rst_ready", int'(cif.ready), 1);
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(2);

    // Single cell "a"
    n0 = played.size();
    stim.delete();
    stim.push_back(6'b100000);
    push_stim();
    @(posedge clk); #1;
    chk("single_first_pin", int'(pin_drv), 6'b100000);
    chk("single_first_stb", int'(strobe), 1);
    repeat (15) @(posedge clk); #1;
    chk("single_last_hold", int'(pin_drv), 6'b100000);
    @(posedge clk); #1;
    chk("single_gap_pin",  int'(pin_drv), 0);
    chk("single_gap_busy", int'(busy), 1);
    repeat (3) @(posedge clk); #1;
    chk("single_gap_end_busy", int'(busy), 1);
    @(posedge clk); #1;
    chk("single_idle_busy", int'(busy), 0);
    chk("single_count", played.size() - n0, 1);

    // Back-to-back: number sign, a, b
    wait_cyc(3);
    n0 = played.size();
    stim.delete();
    stim.push_back(6'b001111);
    stim.push_back(6'b100000);
    stim.push_back(6'b110000);
    push_stim();
    wait_cyc(65);
    chk("b2b_count", played.size() - n0, 3);
    chk("b2b_cell0", int'(played[n0]),     6'b001111);
    chk("b2b_cell1", int'(played[n0 + 1]), 6'b100000);
    chk("b2b_cell2", int'(played[n0 + 2]), 6'b110000);
    chk("b2b_gap01", st_cyc[n0 + 1] - st_cyc[n0],     PERIOD);
    chk("b2b_gap12", st_cyc[n0 + 2] - st_cyc[n0 + 1], PERIOD);
    chk("b2b_ovf", int'(overflow), 0);

    // Overflow: ten consecutive writes into an idle player
    n0 = played.size();
    stim.delete();
    for (int i = 1; i <= 10; i++) stim.push_back(cell_t'(i));
    push_stim();
    chk("ovf_flag",  int'(overflow),  1);
    chk("ovf_ready", int'(cif.ready), 0);
    wait_cyc(9 * PERIOD + 10);
    chk("ovf_played", played.size() - n0, 9);
    for (int i = 0; i < 9; i++) chk("ovf_order", int'(played[n0 + i]), i + 1);
    chk("ovf_sticky", int'(overflow), 1);

    // Full FIFO, write lands on the GAP-end pop edge
    pulse_reset();
    chk("fp_rst_ovf", int'(overflow), 0);
    n0 = played.size();
    stim.delete();
    for (int i = 11; i <= 19; i++) stim.push_back(cell_t'(i));
    push_stim();
    chk("fp_full_ready", int'(cif.ready), 0);
    wait_elapsed(PERIOD - 1);
    cif.cell_valid = 1'b1;
    cif.cell_in    = 6'h2A;
    @(negedge clk);
    cif.cell_valid = 1'b0;
    cif.cell_in    = '0;
    chk("fp_ready_still_full", int'(cif.ready), 0);
    chk("fp_no_ovf", int'(overflow), 0);
    wait_cyc(9 * PERIOD + 10);
    chk("fp_played", played.size() - n0, 10);
    chk("fp_last_cell", int'(played[$]), 6'h2A);

    // Blank cell
    n0 = played.size();
    stim.delete();
    stim.push_back(6'b000000);
    push_stim();
    busy_cnt = 0;
    pin_or   = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      pin_or = pin_or | pin_drv;
    end
    chk("blank_busy_cycles", busy_cnt, PERIOD);
    chk("blank_pins", int'(pin_or), 0);
    chk("blank_strobes", played.size() - n0, 1);

    // Reset at hold cycle 7 with three cells queued
    stim.delete();
    stim.push_back(6'b010101);
    stim.push_back(6'b101010);
    stim.push_back(6'b111000);
    stim.push_back(6'b000111);
    push_stim();
    wait_elapsed(6);
    chk("mid_pin_before", int'(pin_drv), 6'b010101);
    #2 rst = 1'b0;
    #1;
    chk("mid_pin_async",   int'(pin_drv),   0);
    chk("mid_busy_async",  int'(busy),      0);
    chk("mid_strobe_async", int'(strobe),   0);
    chk("mid_ready_async", int'(cif.ready), 1);
    n0 = played.size();
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(60);
    chk("mid_no_strobes", played.size() - n0, 0);
    chk("mid_ready", int'(cif.ready), 1);
    chk("mid_ovf",   int'(overflow),  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
